// File: rtl/enc_secded_encoder_32bit.sv
// Two-stage pipelined extended-Hamming (32,26) SECDED encoder with valid/ready on both sides.
// Optional error injection on the output stage is enabled by defining ENC_ERR_INJECT_EN.
module enc_secded_encoder_32bit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [25:0]      data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      codeword_out,
  output logic [CNT_W-1:0] cw_count
`ifdef ENC_ERR_INJECT_EN
  ,
  input  logic             inj_en,
  input  logic [31:0]      inj_mask
`endif
);

  logic             adv;
  logic             s1_v;
  logic             s2_v;
  logic [25:0]      s1_data;
  logic [4:0]       s1_par;
  logic [31:0]      s1_word;
  logic [31:0]      s2_word;
  logic [31:0]      inj_xor;

  // Data occupies every non-power-of-two position from 3 to 31, ascending.
  function automatic logic [31:0] place_data(input logic [25:0] d);
    return {d[25:11], 1'b0, d[10:4], 1'b0, d[3:1], 1'b0, d[0], 3'b000};
  endfunction

  // Bit j covers every position whose index has bit j set.
  function automatic logic [4:0] hamming_parity(input logic [31:0] w);
    return {^(w & 32'hFFFF_0000), ^(w & 32'hFF00_FF00), ^(w & 32'hF0F0_F0F0),
            ^(w & 32'hCCCC_CCCC), ^(w & 32'hAAAA_AAAA)};
  endfunction

  assign adv          = ~s2_v | out_ready;
  assign in_ready     = adv;
  assign out_valid    = s2_v;
  assign codeword_out = s2_word;

`ifdef ENC_ERR_INJECT_EN
  assign inj_xor = inj_en ? inj_mask : 32'h0;
`else
  assign inj_xor = 32'h0;
`endif

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    s1_word     = place_data(s1_data);
    s1_word[1]  = s1_par[0];
    s1_word[2]  = s1_par[1];
    s1_word[4]  = s1_par[2];
    s1_word[8]  = s1_par[3];
    s1_word[16] = s1_par[4];
    s1_word[0]  = ^s1_word[31:1];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s1_data <= '0;
      s1_par  <= '0;
      s2_word <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      if (in_valid) begin
        s1_data <= data_in;
        s1_par  <= hamming_parity(place_data(data_in));
      end
      // Only real words reach the output register so it holds its last value while idle.
      if (s1_v) s2_word <= s1_word ^ inj_xor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cw_count <= '0;
    else if (out_valid & out_ready) cw_count <= cw_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_enc_secded_encoder_32bit.sv
// Scoreboard bench for enc_secded_encoder_32bit: random stimulus vs. a positional Hamming model.
module tb_enc_secded_encoder_32bit;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [25:0]      data_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      codeword_out;
  logic [CNT_W-1:0] cw_count;
`ifdef ENC_ERR_INJECT_EN
  logic             inj_en = 1'b0;
  logic [31:0]      inj_mask = '0;
`endif

  typedef struct {
    logic [31:0] word;
    bit          dirty;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   accepted = 0;
  int   popped = 0;

  always #5 clk = ~clk;

  enc_secded_encoder_32bit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .codeword_out (codeword_out),
    .cw_count     (cw_count)
`ifdef ENC_ERR_INJECT_EN
    ,
    .inj_en       (inj_en),
    .inj_mask     (inj_mask)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: scatter data over non-power-of-two positions, then set the parity positions
  // so the XOR of all set-bit indices is zero, then make the whole word even parity.
  function automatic logic [31:0] ref_word(input logic [25:0] d);
    logic [31:0] w;
    int          idx;
    int          s;
    w   = '0;
    idx = 0;
    for (int k = 1; k < 32; k++) begin
      if ((k & (k - 1)) != 0) begin
        w[k] = d[idx];
        idx++;
      end
    end
    s = 0;
    for (int k = 1; k < 32; k++) if (w[k]) s = s ^ k;
    for (int j = 0; j < 5; j++) if (((s >> j) & 1) != 0) w[1 << j] = 1'b1;
    w[0] = ^w[31:1];
    return w;
  endfunction

  // Decoder-side syndrome: {overall parity, XOR of set-bit indices}.
  function automatic logic [5:0] syndrome(input logic [31:0] cw);
    int s;
    s = 0;
    for (int k = 1; k < 32; k++) if (cw[k]) s = s ^ k;
    return {^cw, s[4:0]};
  endfunction

  task automatic drive_cycle(input bit iv, input logic [25:0] d, input bit ordy,
                             input bit use_ovr, input logic [31:0] ovr);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    data_in   = d;
    out_ready = ordy;
    #1;
    if (iv && in_ready) begin
      e.word  = use_ovr ? ovr : ref_word(d);
      e.dirty = 1'b0;
`ifdef ENC_ERR_INJECT_EN
      if (!use_ovr && inj_en) e.word = e.word ^ inj_mask;
      e.dirty = inj_en && (inj_mask != 32'h0);
`endif
      exp_q.push_back(e);
      accepted++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_codeword", codeword_out, 0);
    check("rst_cw_count", cw_count, 0);
    check("rst_in_ready", in_ready, 1);
    exp_q.delete();
    accepted = 0;
    popped   = 0;
    @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) drive_cycle(0, '0, 1, 0, '0);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops and compares whenever the DUT hands over a word; also checks stall stability.
  initial begin
    bit          stalled;
    logic [31:0] held;
    exp_t        e;
    stalled = 0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          check("stall_valid", out_valid, 1);
          check("stall_stable", codeword_out, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h expected none", codeword_out);
          end else begin
            e = exp_q.pop_front();
            check("codeword", codeword_out, e.word);
            if (e.dirty) check("syndrome_nonzero", syndrome(codeword_out) != 6'h0, 1);
            else         check("syndrome_zero", syndrome(codeword_out), 0);
            popped++;
          end
        end
        stalled = out_valid && !out_ready;
        held    = codeword_out;
      end
    end
  end

  initial begin
    int cycles;
`ifdef ENC_ERR_INJECT_EN
    inj_en   = 1'b0;
    inj_mask = '0;
`endif
    do_reset();

    // Directed words with hand-derived codewords, plus pipeline timing of the first word.
    drive_cycle(1, 26'h0, 1, 1, 32'h0000_0000);
    drive_cycle(1, 26'h0, 1, 1, 32'h0000_0000);
    check("first_word_not_yet_out", out_valid, 0);
    drive_cycle(1, 26'h0000001, 1, 1, 32'h0000_000F);
    check("first_word_out", out_valid, 1);
    drive_cycle(1, 26'h3FFFFFF, 1, 1, 32'hFFFF_FFFF);
    drive_cycle(1, 26'h0, 1, 1, 32'h0000_0000);
    drain();
    check("cw_count_directed", cw_count, 5);

    // Random stream with heavy backpressure.
    do_reset();
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      drive_cycle($urandom_range(3, 0) != 0, 26'($urandom), $urandom_range(1, 0) != 0, 0, '0);
      cycles++;
    end
    check("random_accepted", accepted, 1000);
    drain();
    check("random_popped", popped, 1000);
    check("cw_count_random", cw_count, 1000);

    // Two words in flight under backpressure, then asynchronous reset.
    drive_cycle(1, 26'($urandom), 0, 0, '0);
    drive_cycle(1, 26'($urandom), 0, 0, '0);
    drive_cycle(0, '0, 0, 0, '0);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    do_reset();
    for (int i = 0; i < 10; i++) drive_cycle(0, '0, 1, 0, '0);
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_cw_count", cw_count, 0);

`ifdef ENC_ERR_INJECT_EN
    inj_en   = 1'b1;
    inj_mask = 32'h0000_0100;
    drive_cycle(1, 26'h0, 1, 1, 32'h0000_0100);
    drain();
    inj_en = 1'b0;
    drive_cycle(1, 26'h0, 1, 1, 32'h0000_0000);
    drain();
    for (int i = 0; i < 20; i++) drive_cycle(1, 26'($urandom), 1, 0, '0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
